// File: rtl/saturation_monitor_if.sv
// Sample/statistics bundle between an upstream arithmetic stage (master)
// and the saturation monitor (slave).
interface saturation_monitor_if #(
    parameter int IW = 22,
    parameter int OW = 16,
    parameter int CW = 16,
    parameter int RW = 8
);
    logic          en;
    logic          clr;
    logic [IW-1:0] sig_in;
    logic [OW-1:0] sig_out;
    logic          valid_out;
    logic          sat_hi;
    logic          sat_lo;
    logic          sticky_hi;
    logic          sticky_lo;
    logic [CW-1:0] event_count;
    logic [RW-1:0] run_len;
    logic          alarm;

    modport master (
        output en, clr, sig_in,
        input  sig_out, valid_out, sat_hi, sat_lo, sticky_hi, sticky_lo,
               event_count, run_len, alarm
    );

    modport slave (
        input  en, clr, sig_in,
        output sig_out, valid_out, sat_hi, sat_lo, sticky_hi, sticky_lo,
               event_count, run_len, alarm
    );
endinterface

// File: rtl/saturation_monitor.sv
// Registered IW->OW signed saturation stage with clamp statistics:
// per-sample clamp flags, sticky polarity flags, saturating event counter,
// consecutive-run length and a sticky run-length alarm.
module saturation_monitor #(
    parameter int IW        = 22,
    parameter int OW        = 16,
    parameter int CW        = 16,
    parameter int RW        = 8,
    parameter int RUN_LIMIT = 4
) (
    input  logic                clk,
    input  logic                rst,
    saturation_monitor_if.slave bus
);
    localparam logic [OW-1:0] SAT_MAX = {1'b0, {(OW-1){1'b1}}};
    localparam logic [OW-1:0] SAT_MIN = {1'b1, {(OW-1){1'b0}}};
    localparam logic [CW-1:0] EV_MAX  = {CW{1'b1}};
    localparam logic [RW-1:0] RUN_MAX = {RW{1'b1}};
    localparam logic [RW-1:0] RUN_LIM = RW'(RUN_LIMIT);

    logic [OW-1:0] sig_out_reg,     sig_out_next;
    logic          valid_reg,       valid_next;
    logic          sat_hi_reg,      sat_hi_next;
    logic          sat_lo_reg,      sat_lo_next;
    logic          sticky_hi_reg,   sticky_hi_next;
    logic          sticky_lo_reg,   sticky_lo_next;
    logic [CW-1:0] event_count_reg, event_count_next;
    logic [RW-1:0] run_len_reg,     run_len_next;
    logic          alarm_reg,       alarm_next;

    logic          pos_ovf;
    logic          neg_ovf;
    logic [OW-1:0] sat_value;
    logic [IW-OW-1:0] guard_bits;

    // Overflow detection: the bits between the sign and the output MSB must
    // all equal the sign bit, otherwise the sample does not fit in OW bits.
    always_comb begin
        guard_bits = bus.sig_in[IW-2:OW-1];
        pos_ovf    = ~bus.sig_in[IW-1] & (|guard_bits);
        neg_ovf    =  bus.sig_in[IW-1] & ~(&guard_bits);
        if (pos_ovf)
            sat_value = SAT_MAX;
        else if (neg_ovf)
            sat_value = SAT_MIN;
        else
            sat_value = bus.sig_in[OW-1:0];
    end

    // Next-state: clr zeroes the statistics base, then an accepted sample
    // is folded in on top of that base in the same cycle.
    always_comb begin
        logic          sticky_hi_base;
        logic          sticky_lo_base;
        logic [CW-1:0] event_base;
        logic [RW-1:0] run_base;
        logic          alarm_base;

        sticky_hi_base = bus.clr ? 1'b0 : sticky_hi_reg;
        sticky_lo_base = bus.clr ? 1'b0 : sticky_lo_reg;
        event_base     = bus.clr ? '0   : event_count_reg;
        run_base       = bus.clr ? '0   : run_len_reg;
        alarm_base     = bus.clr ? 1'b0 : alarm_reg;

        valid_next       = bus.en;
        sig_out_next     = sig_out_reg;
        sat_hi_next      = sat_hi_reg;
        sat_lo_next      = sat_lo_reg;
        sticky_hi_next   = sticky_hi_base;
        sticky_lo_next   = sticky_lo_base;
        event_count_next = event_base;
        run_len_next     = run_base;

        if (bus.en) begin
            sig_out_next = sat_value;
            sat_hi_next  = pos_ovf;
            sat_lo_next  = neg_ovf;
            if (pos_ovf || neg_ovf) begin
                if (event_base != EV_MAX)
                    event_count_next = event_base + CW'(1);
                sticky_hi_next = sticky_hi_base | pos_ovf;
                sticky_lo_next = sticky_lo_base | neg_ovf;
                // A nonzero run means the last accepted sample was clamped,
                // so sat_hi_reg still holds that sample's polarity.
                if (run_base != '0 && pos_ovf == sat_hi_reg) begin
                    if (run_base != RUN_MAX)
                        run_len_next = run_base + RW'(1);
                end else begin
                    run_len_next = RW'(1);
                end
            end else begin
                run_len_next = '0;
            end
        end

        alarm_next = alarm_base | (run_len_next >= RUN_LIM);
    end

    // State registers, cleared immediately by the asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sig_out_reg     <= '0;
            valid_reg       <= 1'b0;
            sat_hi_reg      <= 1'b0;
            sat_lo_reg      <= 1'b0;
            sticky_hi_reg   <= 1'b0;
            sticky_lo_reg   <= 1'b0;
            event_count_reg <= '0;
            run_len_reg     <= '0;
            alarm_reg       <= 1'b0;
        end else begin
            sig_out_reg     <= sig_out_next;
            valid_reg       <= valid_next;
            sat_hi_reg      <= sat_hi_next;
            sat_lo_reg      <= sat_lo_next;
            sticky_hi_reg   <= sticky_hi_next;
            sticky_lo_reg   <= sticky_lo_next;
            event_count_reg <= event_count_next;
            run_len_reg     <= run_len_next;
            alarm_reg       <= alarm_next;
        end
    end

    assign bus.sig_out     = sig_out_reg;
    assign bus.valid_out   = valid_reg;
    assign bus.sat_hi      = sat_hi_reg;
    assign bus.sat_lo      = sat_lo_reg;
    assign bus.sticky_hi   = sticky_hi_reg;
    assign bus.sticky_lo   = sticky_lo_reg;
    assign bus.event_count = event_count_reg;
    assign bus.run_len     = run_len_reg;
    assign bus.alarm       = alarm_reg;
endmodule

// File: tb/tb_saturation_monitor.sv
// Directed bench for saturation_monitor: a main instance (CW=16) and a
// narrow-counter instance (CW=4) share the same stimulus. Sample results go
// through a scoreboard queue; statistics are tracked by an integer model.
module tb_saturation_monitor;
    localparam int IW = 22;
    localparam int OW = 16;
    localparam int CW = 16;
    localparam int RW = 8;
    localparam int RL = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    saturation_monitor_if #(.IW(IW), .OW(OW), .CW(CW), .RW(RW)) bus ();
    saturation_monitor_if #(.IW(IW), .OW(OW), .CW(4),  .RW(RW)) bus4 ();

    assign bus4.en     = bus.en;
    assign bus4.clr    = bus.clr;
    assign bus4.sig_in = bus.sig_in;

    saturation_monitor #(.IW(IW), .OW(OW), .CW(CW), .RW(RW), .RUN_LIMIT(RL)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    saturation_monitor #(.IW(IW), .OW(OW), .CW(4), .RW(RW), .RUN_LIMIT(RL)) dut4 (
        .clk (clk),
        .rst (rst),
        .bus (bus4.slave)
    );

    typedef struct {
        logic [15:0] out;
        logic        hi;
        logic        lo;
    } exp_t;

    exp_t sb[$];

    int checks = 0;
    int errors = 0;

    // statistics model
    int m_ev, m_ev4, m_run;
    bit m_sh, m_sl, m_al, m_lasthi;
    // last delivered sample (held while idle)
    logic [15:0] h_out;
    bit h_hi, h_lo;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
            $error("check %s", tag);
        end
    endtask

    task automatic model_reset();
        m_ev = 0; m_ev4 = 0; m_run = 0;
        m_sh = 0; m_sl = 0; m_al = 0; m_lasthi = 0;
        h_out = '0; h_hi = 0; h_lo = 0;
        sb.delete();
    endtask

    task automatic check_cycle(input bit exp_valid);
        exp_t e;
        chk("valid_out", 32'(bus.valid_out), 32'(exp_valid));
        if (bus.valid_out) begin
            chk("sb_nonempty", 32'(sb.size() != 0), 32'd1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                h_out = e.out; h_hi = e.hi; h_lo = e.lo;
            end
        end
        chk("sig_out",     32'(bus.sig_out),      32'(h_out));
        chk("sat_hi",      32'(bus.sat_hi),       32'(h_hi));
        chk("sat_lo",      32'(bus.sat_lo),       32'(h_lo));
        chk("sticky_hi",   32'(bus.sticky_hi),    32'(m_sh));
        chk("sticky_lo",   32'(bus.sticky_lo),    32'(m_sl));
        chk("event_count", 32'(bus.event_count),  32'(m_ev));
        chk("event4",      32'(bus4.event_count), 32'(m_ev4));
        chk("run_len",     32'(bus.run_len),      32'(m_run));
        chk("alarm",       32'(bus.alarm),        32'(m_al));
        $display("t=%0t en=%0b clr=%0b sig_in=%0d -> sig_out=%h v=%0b hi=%0b lo=%0b ev=%0d ev4=%0d run=%0d alarm=%0b",
                 $time, bus.en, bus.clr, $signed(bus.sig_in), bus.sig_out, bus.valid_out,
                 bus.sat_hi, bus.sat_lo, bus.event_count, bus4.event_count, bus.run_len, bus.alarm);
    endtask

    task automatic step(input bit e, input int v, input bit c);
        logic [31:0] vv;
        bit hi, lo;
        exp_t x;
        @(negedge clk);
        bus.en     = e;
        bus.clr    = c;
        bus.sig_in = IW'(v);
        vv = v;
        if (c) begin
            m_ev = 0; m_ev4 = 0; m_run = 0; m_sh = 0; m_sl = 0; m_al = 0;
        end
        if (e) begin
            hi = (v > 32767);
            lo = (v < -32768);
            x.out = hi ? 16'h7FFF : (lo ? 16'h8000 : vv[15:0]);
            x.hi  = hi;
            x.lo  = lo;
            sb.push_back(x);
            if (hi || lo) begin
                m_ev  = (m_ev  < 65535) ? m_ev + 1  : 65535;
                m_ev4 = (m_ev4 < 15)    ? m_ev4 + 1 : 15;
                if (m_run > 0 && m_lasthi == hi)
                    m_run = (m_run < 255) ? m_run + 1 : 255;
                else
                    m_run = 1;
                m_lasthi = hi;
                m_sh = m_sh | hi;
                m_sl = m_sl | lo;
            end else begin
                m_run = 0;
            end
        end
        if (m_run >= RL) m_al = 1;
        @(posedge clk);
        #1;
        check_cycle(e);
    endtask

    initial begin
        bus.en = 1'b0; bus.clr = 1'b0; bus.sig_in = '0;
        rst = 1'b1;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_cycle(1'b0);
        @(negedge clk);
        rst = 1'b0;

        // pass-through
        step(1, 1000, 0);
        step(1, 32767, 0);
        step(1, -32768, 0);
        step(1, -1, 0);
        chk("pass_sig", 32'(bus.sig_out), 32'h0000FFFF);

        // positive clamp
        step(1, 40000, 0);
        step(1, 2097151, 0);
        chk("pos_ev", 32'(bus.event_count), 32'd2);
        chk("pos_run", 32'(bus.run_len), 32'd2);

        // alarm threshold with idle gaps
        step(1, -40000, 0); step(0, 0, 0);
        step(1, -40000, 0); step(0, 0, 0);
        step(1, -40000, 0); step(0, 0, 0);
        step(1, -40000, 0);
        chk("alarm_run", 32'(bus.run_len), 32'd4);
        chk("alarm_set", 32'(bus.alarm), 32'd1);
        step(1, 5, 0);
        chk("alarm_hold", 32'(bus.alarm), 32'd1);
        chk("alarm_run0", 32'(bus.run_len), 32'd0);

        // polarity switch after a clear
        step(0, 0, 1);
        step(1, 40000, 0);
        step(1, 40000, 0);
        step(1, 40000, 0);
        chk("pol_run3", 32'(bus.run_len), 32'd3);
        step(1, -40000, 0);
        chk("pol_run1", 32'(bus.run_len), 32'd1);
        chk("pol_ev", 32'(bus.event_count), 32'd4);

        // build ev=10 with alarm, then clear with a simultaneous sample
        for (int i = 0; i < 6; i++) step(1, -40000, 0);
        chk("pre_clr_ev", 32'(bus.event_count), 32'd10);
        step(1, 50000, 1);
        chk("clr_ev", 32'(bus.event_count), 32'd1);
        chk("clr_run", 32'(bus.run_len), 32'd1);
        chk("clr_alarm", 32'(bus.alarm), 32'd0);

        // narrow counter saturation
        for (int i = 0; i < 20; i++) step(1, 50000, 0);
        chk("ev4_sat", 32'(bus4.event_count), 32'd15);
        step(0, 0, 0);

        // asynchronous reset between edges
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        check_cycle(1'b0);
        chk("rst_ev4", 32'(bus4.event_count), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        step(1, 50000, 0);
        chk("post_rst_run", 32'(bus.run_len), 32'd1);
        step(0, 0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
